uart1655_axil_fractickgen: RTL and testbench
============================================

# uart1655_axil_fractickgen

Parametrised successor to the UART baud tick generator: integer prescaler plus fractional accumulator for non-integer divisors, an oversample sub-tick counter producing a per-bit strobe, glitch-free divisor updates at period boundaries, and an explicit restart. It sits between the divisor-latch registers and the TX/RX shift engines, which consume `tick` (oversample rate) and `bit_tick` (bit rate).

## Interface
- `PRESC_W`, 16: width of integer divisor `presc`.
- `FRAC_W`, 4: width of fractional divisor `frac`. Fraction = `frac`/2^`FRAC_W`.
- `OVS`, 16: ticks per bit. Power of two, ≥2.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `presc`  in  `PRESC_W`  integer divisor. 0 = stop, 1 = passthrough.
- `frac`  in  `FRAC_W`  fractional divisor.
- `enable`  in  1  0 freezes all state.
- `load`  in  1  1-cycle pulse: capture `presc`/`frac` and restart.
- `tick`  out  1  registered 1-cycle pulse per divided period.
- `bit_tick`  out  1  registered; high with every `OVS`-th `tick`.
- `running`  out  1  registered `presc_q != 0`.

## Operation
- State: `cnt[PRESC_W]`, `acc[FRAC_W]`, `sub[log2 OVS]`, `presc_q`, `frac_q`. All, plus every output, reset to 0.
- Priority per edge: `load`, then `!enable`, then stop, then boundary, then count.
- `load`=1 (ignores `enable`): `presc_q`←`presc`, `frac_q`←`frac`; `cnt`, `acc`, `sub`←0; `tick`, `bit_tick`←0.
- `enable`=0: all counters and `presc_q`/`frac_q` hold; `tick`, `bit_tick`←0.
- Stop (`presc_q`==0): `presc_q`←`presc`, `frac_q`←`frac`, `cnt`, `acc`←0, no tick. A nonzero `presc` therefore takes effect on the next edge.
- Boundary (`cnt`==0, `presc_q`!=0): `tick`←1; `{carry,acc}`←`acc`+`frac`; `cnt`←`presc`−1+`carry`; `presc_q`←`presc`, `frac_q`←`frac`; `bit_tick`←(`sub`==`OVS`−1); `sub`←`sub`+1 (wraps). If `presc`==0 at the boundary, this tick is still emitted; then `cnt`, `acc`←0 and the block enters stop.
- Otherwise: `cnt`←`cnt`−1; `tick`, `bit_tick`←0.
- Width rule: `presc`−1+`carry` ≤ 2^`PRESC_W`−1, so no overflow. The accumulator carry is the bit out of the `FRAC_W`-bit sum.
- Average period = `presc` + `frac`/2^`FRAC_W` cycles. Each individual period is `presc` or `presc`+1.
- Divisor changes without `load` never shorten or split the period in progress.

## Timing
- From stop or after `load`, the first `tick` is registered on the 2nd edge: one edge to capture, one at `cnt`==0.
- With `presc`=N≥1 and `frac`=0: `tick` is one cycle wide every N cycles. N=1 gives `tick` constantly high.
- `bit_tick` is coincident with `tick`, on the 16th, 32nd, … tick after restart (`OVS`=16).
- `reset_n` low forces all outputs to 0 asynchronously, mid-period included. Release is sampled on the next `clk` edge.
- `enable` low→high resumes exactly where it froze. No tick is lost or duplicated, only delayed.

## Structure
- Shared package `uart1655_axil_pkg` holds the defaults `PRESC_W_DEF`=16, `FRAC_W_DEF`=4, `OVS_DEF`=16 and the divisor register field widths reused by the register block.
- Single module, no sub-module. The fractional accumulator is about 5 lines and does not justify its own block.

## Test plan
- Reset, `presc`=5, `frac`=0, `enable`=1 → `tick` pulses every 5 cycles, first pulse on the 2nd edge after release; `bit_tick` every 80 cycles; `running`=1.
- `presc`=1, `frac`=0 → `tick` continuously high from the 2nd edge; `bit_tick` every 16 cycles.
- `presc`=0 for 200 cycles → `tick`, `bit_tick`, `running` stay 0. Then `presc`=3 → first tick 2 edges later, period 3.
- `presc`=4, `frac`=8 → periods alternate 4,5,4,5; 16 ticks span 72 cycles; one `bit_tick`.
- Mid-period change `presc` 5→3 without `load` → current period still 5, following periods 3. Same change with `load` → tick 2 edges after `load`, `sub` restarts (`bit_tick` 16 ticks later).
- `enable`=0 for 7 cycles mid-period → no ticks during the gap, period resumes with remaining count. Assert `reset_n`=0 mid-`tick` → `tick` drops immediately, all state 0.

Source files
------------

// File: rtl/uart1655_axil_pkg.sv
// Shared UART divisor defaults and register field widths, used by the tick
// generator and the divisor-latch register block.
package uart1655_axil_pkg;

    localparam int PRESC_W_DEF = 16;
    localparam int FRAC_W_DEF  = 4;
    localparam int OVS_DEF     = 16;

    // Divisor latch fields as laid out in the register map.
    localparam int DLL_W = 8;
    localparam int DLM_W = 8;
    localparam int DLF_W = FRAC_W_DEF;

    // Which rule governs the current edge, in priority order.
    typedef enum logic [2:0] {
        TG_LOAD,
        TG_HOLD,
        TG_STOP,
        TG_BOUND,
        TG_COUNT
    } tg_mode_e;

endpackage

// File: rtl/uart1655_axil_fractickgen.sv
// Baud tick generator: integer prescaler with fractional carry accumulator,
// oversample sub-counter for the per-bit strobe, restart on load.
module uart1655_axil_fractickgen
    import uart1655_axil_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int OVS     = OVS_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PRESC_W-1:0] presc,
    input  logic [FRAC_W-1:0]  frac,
    input  logic               enable,
    input  logic               load,
    output logic               tick,
    output logic               bit_tick,
    output logic               running
);

    localparam int SUB_W = $clog2(OVS);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);

    logic [PRESC_W-1:0] cnt_q, cnt_d, presc_q, presc_d, cnt_reload;
    logic [FRAC_W-1:0]  acc_q, acc_d, frac_q, frac_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic               tick_q, tick_d, bit_tick_q, bit_tick_d, running_q;
    logic [FRAC_W:0]    acc_sum;
    tg_mode_e           mode;

    // Carry out of the fractional sum stretches this period by one cycle.
    assign acc_sum    = {1'b0, acc_q} + {1'b0, frac};
    assign cnt_reload = presc - PRESC_W'(1) + PRESC_W'(acc_sum[FRAC_W]);

    always_comb begin
        if (load)                 mode = TG_LOAD;
        else if (!enable)         mode = TG_HOLD;
        else if (presc_q == '0)   mode = TG_STOP;
        else if (cnt_q == '0)     mode = TG_BOUND;
        else                      mode = TG_COUNT;
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        sub_d      = sub_q;
        presc_d    = presc_q;
        frac_d     = frac_q;
        tick_d     = 1'b0;
        bit_tick_d = 1'b0;
        case (mode)
            TG_LOAD: begin
                presc_d = presc;
                frac_d  = frac;
                cnt_d   = '0;
                acc_d   = '0;
                sub_d   = '0;
            end
            TG_HOLD: ;
            TG_STOP: begin
                presc_d = presc;
                frac_d  = frac;
                cnt_d   = '0;
                acc_d   = '0;
            end
            TG_BOUND: begin
                tick_d     = 1'b1;
                bit_tick_d = (sub_q == SUB_LAST);
                sub_d      = sub_q + SUB_W'(1);
                presc_d    = presc;
                frac_d     = frac;
                // A zero divisor still emits this tick, then parks in stop.
                if (presc == '0) begin
                    cnt_d = '0;
                    acc_d = '0;
                end else begin
                    cnt_d = cnt_reload;
                    acc_d = acc_sum[FRAC_W-1:0];
                end
            end
            TG_COUNT: cnt_d = cnt_q - PRESC_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            sub_q      <= '0;
            presc_q    <= '0;
            frac_q     <= '0;
            tick_q     <= 1'b0;
            bit_tick_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            sub_q      <= sub_d;
            presc_q    <= presc_d;
            frac_q     <= frac_d;
            tick_q     <= tick_d;
            bit_tick_q <= bit_tick_d;
            running_q  <= (presc_d != '0);
        end
    end

    assign tick     = tick_q;
    assign bit_tick = bit_tick_q;
    assign running  = running_q;

endmodule

// File: tb/tb_uart1655_axil_fractickgen.sv
// Directed bench for the fractional baud tick generator; expected periods and
// strobe positions are worked out by hand from the divisor values.
module tb_uart1655_axil_fractickgen;

    logic        clk;
    logic        reset_n;
    logic [15:0] presc;
    logic [3:0]  frac;
    logic        enable;
    logic        load;
    logic        tick;
    logic        bit_tick;
    logic        running;

    int n_checks = 0;
    int n_err    = 0;

    uart1655_axil_fractickgen #(.PRESC_W(16), .FRAC_W(4), .OVS(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .presc    (presc),
        .frac     (frac),
        .enable   (enable),
        .load     (load),
        .tick     (tick),
        .bit_tick (bit_tick),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until the next tick, starting from an offset already elapsed.
    task automatic measure_from(input int start, output int cyc);
        cyc = start;
        do begin
            step(1);
            cyc++;
        end while (!tick && cyc < 60);
    endtask

    // Walk n tick periods; total cycles and number of bit strobes seen.
    task automatic run_ticks(input int n, output int cyc, output int bits);
        int p;
        cyc  = 0;
        bits = 0;
        for (int i = 0; i < n; i++) begin
            measure_from(0, p);
            cyc += p;
            if (bit_tick) bits++;
        end
    endtask

    initial begin
        int cyc, bits, seen;
        reset_n = 1'b1;
        presc   = 16'd5;
        frac    = 4'd0;
        enable  = 1'b1;
        load    = 1'b0;
        #2 reset_n = 1'b0;
        step(3);
        chk("reset_outputs", {29'd0, tick, bit_tick, running}, 32'd0);

        // presc=5 from reset release
        reset_n = 1'b1;
        step(1);
        chk("rel_edge1_tick", tick, 0);
        chk("rel_running", running, 1);
        step(1);
        chk("rel_edge2_tick", tick, 1);
        chk("p5_first_bit", bit_tick, 0);
        step(1);
        chk("p5_tick_width", tick, 0);
        measure_from(1, cyc);
        chk("p5_period", cyc, 5);
        run_ticks(14, cyc, bits);
        chk("p5_to_tick16", cyc, 70);
        chk("p5_bits_before", bits, 1);
        chk("p5_bit_on_16", bit_tick, 1);
        run_ticks(16, cyc, bits);
        chk("p5_bit_period", cyc, 80);
        chk("p5_bit_count", bits, 1);

        // presc=1 passthrough via load
        presc = 16'd1;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        chk("p1_load_edge", tick, 0);
        step(1);
        chk("p1_first", tick, 1);
        run_ticks(15, cyc, bits);
        chk("p1_15_cycles", cyc, 15);
        chk("p1_bit_16th", bit_tick, 1);
        run_ticks(16, cyc, bits);
        chk("p1_bit_period", cyc, 16);
        chk("p1_bit_count", bits, 1);

        // presc=0: last tick emitted, then stop
        presc = 16'd0;
        step(1);
        chk("p0_last_tick", tick, 1);
        chk("p0_running", running, 0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (tick || bit_tick || running) seen++;
        end
        chk("p0_quiet", seen, 0);
        presc = 16'd3;
        step(1);
        chk("p3_capture", {30'd0, tick, running}, 32'd1);
        step(1);
        chk("p3_first", tick, 1);
        measure_from(0, cyc);
        chk("p3_period", cyc, 3);

        // fractional 4 + 8/16
        presc = 16'd4;
        frac  = 4'd8;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        chk("f_first", tick, 1);
        measure_from(0, cyc);
        chk("f_per1", cyc, 4);
        measure_from(0, cyc);
        chk("f_per2", cyc, 5);
        measure_from(0, cyc);
        chk("f_per3", cyc, 4);
        measure_from(0, cyc);
        chk("f_per4", cyc, 5);
        load = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        run_ticks(16, cyc, bits);
        chk("f_16_span", cyc, 72);
        chk("f_16_bits", bits, 1);

        // mid-period change without load keeps current period
        presc = 16'd5;
        frac  = 4'd0;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        step(2);
        presc = 16'd3;
        measure_from(2, cyc);
        chk("chg_cur_period", cyc, 5);
        measure_from(0, cyc);
        chk("chg_next_period", cyc, 3);

        // same change with load restarts
        presc = 16'd5;
        measure_from(0, cyc);
        measure_from(0, cyc);
        step(2);
        presc = 16'd3;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        chk("ld_edge1", tick, 0);
        step(1);
        chk("ld_edge2", tick, 1);
        chk("ld_no_bit", bit_tick, 0);
        run_ticks(15, cyc, bits);
        chk("ld_span", cyc, 45);
        chk("ld_bit_16th", {30'd0, bit_tick, bits[0]}, 32'd3);

        // enable gap of 7 cycles mid-period
        presc = 16'd5;
        measure_from(0, cyc);
        measure_from(0, cyc);
        step(2);
        enable = 1'b0;
        seen   = 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (tick || bit_tick) seen++;
        end
        enable = 1'b1;
        chk("en_gap_quiet", seen, 0);
        measure_from(9, cyc);
        chk("en_resume", cyc, 12);
        measure_from(0, cyc);
        chk("en_after", cyc, 5);

        // async reset while tick is high
        presc = 16'd1;
        load  = 1'b1;
        step(1);
        load = 1'b0;
        step(1);
        chk("rst_pre_tick", tick, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async", {29'd0, tick, bit_tick, running}, 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("rst_rel_edge1", {30'd0, tick, running}, 32'd1);
        step(1);
        chk("rst_rel_edge2", tick, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
